// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port; one IDLE cycle between grants,
// done pulses combinational with mDone; requesters hold requests and see stall until done.
module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int D_MAX   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [15:0] iAddr,
  output logic [15:0] iData,
  output logic        iDone,
  output logic        iStall,
  input  logic        dRd,
  input  logic        dWr,
  input  logic [15:0] dAddr,
  input  logic [15:0] dDataIn,
  output logic [15:0] dDataOut,
  output logic        dDone,
  output logic        dStall,
  output logic        mRd,
  output logic        mWr,
  output logic [15:0] mAddr,
  output logic [15:0] mDataIn,
  input  logic [15:0] mDataOut,
  input  logic        mDone,
  output logic        err
);

  localparam logic [3:0] TO_LIM = 4'(TIMEOUT);
  localparam logic [1:0] DC_LIM = 2'(D_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  dcnt, dcnt_nxt;
  logic [3:0]  tcnt, tcnt_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] wdat_q, wdat_nxt;
  logic        wr_q, wr_nxt;
  logic        err_q, err_nxt;
  logic        d_req;
  logic        busy;

  assign d_req = dRd | dWr;
  assign busy  = (state == BUSY_I) || (state == BUSY_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dcnt   <= '0;
      tcnt   <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      dcnt   <= dcnt_nxt;
      tcnt   <= tcnt_nxt;
      addr_q <= addr_nxt;
      wdat_q <= wdat_nxt;
      wr_q   <= wr_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    tcnt_nxt  = tcnt;
    addr_nxt  = addr_q;
    wdat_nxt  = wdat_q;
    wr_nxt    = wr_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (!iReq) dcnt_nxt = '0;
        // Simultaneous read and write is a protocol violation, checked before any grant.
        if (dRd && dWr) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else if (d_req && (!iReq || dcnt < DC_LIM)) begin
          state_nxt = BUSY_D;
          addr_nxt  = dAddr;
          wdat_nxt  = dDataIn;
          wr_nxt    = dWr;
          tcnt_nxt  = '0;
          if (iReq && dcnt != 2'b11) dcnt_nxt = dcnt + 2'd1;
        end else if (iReq) begin
          state_nxt = BUSY_I;
          addr_nxt  = iAddr;
          wdat_nxt  = '0;
          wr_nxt    = 1'b0;
          tcnt_nxt  = '0;
          dcnt_nxt  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mDone) begin
          state_nxt = IDLE;
        end else if (tcnt + 4'd1 == TO_LIM) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
          tcnt_nxt  = TO_LIM;
        end else begin
          tcnt_nxt = tcnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign mRd     = busy && !wr_q;
  assign mWr     = busy && wr_q;
  assign mAddr   = addr_q;
  assign mDataIn = wdat_q;

  // Done pulses are suppressed while reset is asserted so an abandoned transfer never completes.
  assign iDone    = !rst && (state == BUSY_I) && mDone;
  assign iData    = iDone ? mDataOut : '0;
  assign dDone    = !rst && (state == BUSY_D) && mDone;
  assign dDataOut = (dDone && !wr_q) ? mDataOut : '0;

  assign iStall = iReq & ~iDone;
  assign dStall = d_req & ~dDone;
  assign err    = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max wait cycles for mDone before error.
REQ-002 SHALL have parameter D_MAX, default 2: consecutive data grants allowed while fetch waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 iReq  input  1  fetch read request, held until iDone.
REQ-006 iAddr  input  16  fetch address.
REQ-007 iData  output  16  fetch read data, valid when iDone=1.
REQ-008 iDone  output  1  fetch transaction complete, one-cycle pulse.
REQ-009 iStall  output  1  fetch must hold request and freeze.
REQ-010 dRd, dWr  input  1 each  data read / write request, held until dDone.
REQ-011 dAddr, dDataIn  input  16 each  data address, write data.
REQ-012 dDataOut  output  16  data read result, valid when dDone=1.
REQ-013 dDone, dStall  output  1 each  data complete pulse / data stall.
REQ-014 mRd, mWr, mAddr, mDataIn  output  1,1,16,16  shared memory port command.
REQ-015 mDataOut, mDone  input  16,1  memory read data, completion pulse.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 SHALL implement states IDLE, BUSY_I, BUSY_D, ERR, encoded in a registered state vector.
REQ-018 IDLE: dRd|dWr pending and (iReq=0 or dCount<D_MAX) -> BUSY_D; else iReq -> BUSY_I; else stay IDLE.
REQ-019 On entering BUSY_x, SHALL latch address, write data and rd/wr kind into internal registers; mAddr/mDataIn/mRd/mWr driven only from latched values.
REQ-020 In BUSY_x, SHALL hold mRd or mWr asserted every cycle until mDone=1; mRd, mWr SHALL be 0 in IDLE and ERR.
REQ-021 On mDone in BUSY_I: iDone=1, iData=mDataOut same cycle (combinational), next state IDLE.
REQ-022 On mDone in BUSY_D: dDone=1, dDataOut=mDataOut (reads; 0 for writes), next state IDLE.
REQ-023 Minimum latency: request seen in IDLE cycle N -> mRd/mWr asserted cycle N+1 -> done same cycle as mDone; back-to-back grants separated by one IDLE cycle.
REQ-024 iStall = iReq & ~iDone; dStall = (dRd|dWr) & ~dDone; in ERR both stall outputs = requester's request.
REQ-025 dCount (2-bit saturating): increment on each BUSY_D entry while iReq=1; clear on BUSY_I entry or when iReq=0 in IDLE.
REQ-026 dRd and dWr both 1 in IDLE SHALL be treated as illegal: set err, enter ERR, no memory command issued.
REQ-027 Timeout counter (4-bit) SHALL clear on BUSY entry, increment each BUSY cycle without mDone; reaching TIMEOUT -> err=1, state ERR.
REQ-028 mDone while IDLE or ERR SHALL be ignored (no done pulse, no state change).
REQ-029 ERR is terminal until rst; err stays 1, no commands issued.
REQ-030 Requester dropping its request mid-BUSY SHALL NOT abort the transaction; the done pulse is still generated.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, dCount=0, timeout=0, latched regs=0, err=0.
REQ-032 Reset mid-transaction SHALL abandon it: mRd=mWr=0 from the following cycle, no done pulse.
REQ-033 While in reset, iDone=dDone=0, iData=dDataOut=0.

Verification
REQ-034 iReq=1, iAddr=0x0040, mDone 3 cycles after mRd -> mAddr=0x0040 held 3 cycles, iDone pulse with iData=mDataOut, iStall low that cycle.
REQ-035 iReq and dRd same cycle, dAddr=0x1000 -> data granted first; fetch granted next; third data request also granted only after fetch if dCount reached 2.
REQ-036 dWr=1, dAddr=0x2002, dDataIn=0xBEEF -> mWr=1, mAddr=0x2002, mDataIn=0xBEEF until mDone; dDone pulse, dDataOut=0.
REQ-037 dRd=dWr=1 from IDLE -> err=1 next cycle, mRd=mWr=0 thereafter until rst.
REQ-038 BUSY_I with mDone never asserted -> err=1 after 15 cycles; rst then clears err and state IDLE.
REQ-039 rst pulsed during BUSY_D -> no dDone, mWr/mRd low next cycle, fresh iReq served normally afterward.
